// File: rtl/ddr_report_fmt.sv
// ddr_report_fmt: formats DDR3 test completion events as ASCII lines for a UART TX FIFO.
// Optional macro DDR_REPORT_PASS_EN appends " PASS"/" FAIL" to the R line.
module ddr_report_fmt #(
    parameter int                   CNT_WIDTH = 24,
    parameter logic [CNT_WIDTH-1:0] EXPECT_OK = 24'hFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wdone,
    input  logic                 rdone,
    input  logic [CNT_WIDTH-1:0] num_ok,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [7:0]           fifo_wdata,
    output logic                 busy
);

    localparam int DIGITS = CNT_WIDTH / 4;
`ifdef DDR_REPORT_PASS_EN
    localparam int MSG_R  = 12 + DIGITS;
`else
    localparam int MSG_R  = 7 + DIGITS;
`endif
    localparam int IW = $clog2(MSG_R);
    localparam logic [IW-1:0] LAST_W = IW'(2);
    localparam logic [IW-1:0] LAST_R = IW'(MSG_R - 1);

    if (((CNT_WIDTH % 4) != 0) || ($bits(EXPECT_OK) != CNT_WIDTH)) begin : g_bad_cfg
        $error("ddr_report_fmt: CNT_WIDTH must be a multiple of 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND_W,
        SEND_R
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic                  prev_w;
    logic                  prev_r;
    logic                  pend_w;
    logic                  pend_r;
    logic [CNT_WIDTH-1:0]  snap;
    logic [CNT_WIDTH-1:0]  cur_snap;
    logic [IW-1:0]         idx;
    logic                  edge_w;
    logic                  edge_r;
    logic                  start_w;
    logic                  start_r;
    logic                  last;
    logic                  wr;
    logic [7:0]            ch;
    logic [39:0]           tag;

    assign edge_w  = wdone & ~prev_w;
    assign edge_r  = rdone & ~prev_r;
    assign start_w = (state == IDLE) & pend_w;
    assign start_r = (state == IDLE) & ~pend_w & pend_r;

`ifdef DDR_REPORT_PASS_EN
    assign tag = (cur_snap == EXPECT_OK) ? " PASS" : " FAIL";
`else
    assign tag = '0;
`endif

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and write strobe; a reset cycle never writes.
    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        last     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_w) begin
                    state_nx = SEND_W;
                end else if (pend_r) begin
                    state_nx = SEND_R;
                end
            end
            SEND_W: begin
                wr   = ~fifo_full;
                last = (idx == LAST_W);
                if (wr && last) begin
                    state_nx = IDLE;
                end
            end
            SEND_R: begin
                wr   = ~fifo_full;
                last = (idx == LAST_R);
                if (wr && last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            wr = 1'b0;
        end
    end

    // Character decode from state, index and the frozen snapshot.
    always_comb begin
        ch = 8'h00;
        if (state == SEND_W) begin
            if (idx == IW'(0)) begin
                ch = 8'h57;
            end else if (idx == IW'(1)) begin
                ch = 8'h0D;
            end else begin
                ch = 8'h0A;
            end
        end else if (state == SEND_R) begin
            if (idx == IW'(0)) ch = 8'h52;
            if (idx == IW'(1)) ch = 8'h20;
            if (idx == IW'(2)) ch = 8'h4F;
            if (idx == IW'(3)) ch = 8'h4B;
            if (idx == IW'(4)) ch = 8'h3D;
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(5 + i)) begin
                    ch = hex(cur_snap[4*(DIGITS-1-i) +: 4]);
                end
            end
`ifdef DDR_REPORT_PASS_EN
            for (int k = 0; k < 5; k++) begin
                if (idx == IW'(5 + DIGITS + k)) begin
                    ch = tag[8*(4-k) +: 8];
                end
            end
`endif
            if (idx == LAST_R - IW'(1)) ch = 8'h0D;
            if (idx == LAST_R) ch = 8'h0A;
        end
        if (rst) begin
            ch = 8'h00;
        end
    end

    // Edge capture, pending flags, snapshots and character index.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_w   <= 1'b0;
            prev_r   <= 1'b0;
            pend_w   <= 1'b0;
            pend_r   <= 1'b0;
            snap     <= '0;
            cur_snap <= '0;
            idx      <= '0;
        end else begin
            prev_w <= wdone;
            prev_r <= rdone;
            pend_w <= edge_w | (pend_w & ~start_w);
            pend_r <= edge_r | (pend_r & ~start_r);
            if (edge_r) begin
                snap <= num_ok;
            end
            if (start_r) begin
                cur_snap <= snap;
            end
            if (start_w || start_r) begin
                idx <= '0;
            end else if (wr) begin
                idx <= last ? '0 : idx + IW'(1);
            end
        end
    end

    assign fifo_wr    = wr;
    assign fifo_wdata = ch;
    assign busy       = (state != IDLE) | pend_w | pend_r;

    logic unused_tag;
    assign unused_tag = ^tag;

endmodule

// File: tb/tb_ddr_report_fmt.sv
// tb_ddr_report_fmt: directed vector bench for ddr_report_fmt.
// Honours DDR_REPORT_PASS_EN when the design is built with it.
module tb_ddr_report_fmt;

    logic        clk = 1'b0;
    logic        rst;
    logic        wdone;
    logic        rdone;
    logic [23:0] num_ok;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic        busy;

    ddr_report_fmt dut (
        .clk        (clk),
        .rst        (rst),
        .wdone      (wdone),
        .rdone      (rdone),
        .num_ok     (num_ok),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Every written byte with the cycle it was written in.
    byte unsigned qb[$];
    int           qc[$];
    always @(negedge clk) begin
        if (fifo_wr) begin
            qb.push_back(fifo_wdata);
            qc.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          w;
        bit          r;
        logic [23:0] num;
        string       exp;
        int          gap;
    } vec_t;

    vec_t  vt[6];
    string NL;
    string TP;
    string TF;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, output int idle_cyc);
        int n;
        n = 0;
        tick();
        tick();
        while (busy && n < 300) begin
            tick();
            n++;
        end
        idle_cyc = cyc;
        chk({name, " idle"}, int'(busy), 0);
    endtask

    task automatic check_msg(input string name, input string exp,
                             input int gap_at, input int start);
        int m;
        int bad;
        int n;
        m   = -1;
        bad = 0;
        n   = (qb.size() < exp.len()) ? qb.size() : exp.len();
        chk({name, " count"}, qb.size(), exp.len());
        for (int i = 0; i < n; i++) begin
            if (m < 0 && qb[i] != exp.getc(i)) begin
                m = i;
                $display("  %s at %0d got %h want %h", name, i, qb[i], exp.getc(i));
            end
        end
        chk({name, " first bad index"}, m, -1);
        if (start >= 0 && qc.size() > 0) begin
            chk({name, " start cycle"}, qc[0], start);
        end
        if (gap_at != -2) begin
            for (int i = 1; i < qc.size(); i++) begin
                if ((qc[i] - qc[i-1]) != ((i == gap_at) ? 2 : 1)) bad++;
            end
            chk({name, " spacing"}, bad, 0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int start;
        int ic;
        qb.delete();
        qc.delete();
        num_ok = v.num;
        wdone  = v.w;
        rdone  = v.r;
        start  = cyc + 2;
        wait_idle(v.name, ic);
        check_msg(v.name, v.exp, v.gap, start);
        if (qc.size() > 0) begin
            chk({v.name, " busy drop"}, ic, qc[qc.size()-1] + 1);
        end
        wdone = 1'b0;
        rdone = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int    n;
        int    nwr;
        int    nbusy;
        int    dc;
        int    ic;
        int    b4;
        string e1;

        NL = "\015\012";
`ifdef DDR_REPORT_PASS_EN
        TP = " PASS";
        TF = " FAIL";
`else
        TP = "";
        TF = "";
`endif
        vt[0] = '{"w_only", 1'b1, 1'b0, 24'h000000, {"W", NL}, -1};
        vt[1] = '{"r_a3f1", 1'b0, 1'b1, 24'h00A3F1, {"R OK=00A3F1", TF, NL}, -1};
        vt[2] = '{"r_zero", 1'b0, 1'b1, 24'h000000, {"R OK=000000", TF, NL}, -1};
        vt[3] = '{"r_ones", 1'b0, 1'b1, 24'hFFFFFF, {"R OK=FFFFFF", TP, NL}, -1};
        vt[4] = '{"r_9abc", 1'b0, 1'b1, 24'h9ABCDE, {"R OK=9ABCDE", TF, NL}, -1};
        vt[5] = '{"both", 1'b1, 1'b1, 24'h123456,
                  {"W", NL, "R OK=123456", TF, NL}, 3};

        rst       = 1'b1;
        wdone     = 1'b0;
        rdone     = 1'b0;
        fifo_full = 1'b0;
        num_ok    = '0;
        repeat (3) tick();
        chk("reset fifo_wr", int'(fifo_wr), 0);
        chk("reset fifo_wdata", int'(fifo_wdata), 0);
        chk("reset busy", int'(busy), 0);

        rst   = 1'b0;
        nwr   = 0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (fifo_wr) nwr++;
            if (busy) nbusy++;
        end
        chk("quiet writes", nwr + qb.size(), 0);
        chk("quiet busy", nbusy, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // FIFO full for five cycles after the third R character.
        qb.delete();
        qc.delete();
        num_ok = 24'h00A3F1;
        rdone  = 1'b1;
        n = 0;
        while (qb.size() != 3 && n < 50) begin
            tick();
            n++;
        end
        chk("stall reach 3", qb.size(), 3);
        fifo_full = 1'b1;
        repeat (5) tick();
        chk("stall no writes", qb.size(), 3);
        fifo_full = 1'b0;
        dc = cyc;
        wait_idle("stall", ic);
        check_msg("stall", {"R OK=00A3F1", TF, NL}, -2, -1);
        b4 = (qb.size() > 3) ? int'(qb[3]) : -1;
        chk("stall 4th char", b4, 8'h4B);
        chk("stall 4th cycle", (qc.size() > 3) ? qc[3] : -1, dc);
        rdone = 1'b0;
        tick();
        tick();

        // Second rdone edge while the first R line is going out.
        qb.delete();
        qc.delete();
        num_ok = 24'h111111;
        rdone  = 1'b1;
        n = 0;
        while (qb.size() != 2 && n < 50) begin
            tick();
            n++;
        end
        rdone = 1'b0;
        tick();
        num_ok = 24'h2A2B2C;
        rdone  = 1'b1;
        tick();
        num_ok = 24'h000000;
        wait_idle("repeat", ic);
        e1 = {"R OK=111111", TF, NL};
        check_msg("repeat", {e1, "R OK=2A2B2C", TF, NL}, e1.len(), -1);
        rdone = 1'b0;
        tick();
        tick();

        // Reset after the sixth R character with both levels held high.
        qb.delete();
        qc.delete();
        num_ok = 24'h5B07C2;
        wdone  = 1'b1;
        rdone  = 1'b1;
        n = 0;
        while (qb.size() != 9 && n < 60) begin
            tick();
            n++;
        end
        chk("abort reach 9", qb.size(), 9);
        rst = 1'b1;
        tick();
        chk("abort reset cycle", qb.size(), 9);
        rst = 1'b0;
        wait_idle("abort", ic);
        check_msg("abort", {"W", NL, "R OK=5", "W", NL, "R OK=5B07C2", TF, NL}, -2, -1);
        wdone = 1'b0;
        rdone = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
